// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared funct codes, HI/LO unit states and width for the EX stage
package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
               (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative unsigned shift-add multiplier / restoring divider
module muldiv_core #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_div,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                 busy_q;
    logic                 div_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;

    // acc holds {upper product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, b_q};
        if (div_q) begin
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign finish = busy_q && (cnt_q == CNT_W'(WIDTH-1));
    assign acc    = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= '0;
            b_q    <= b_mag;
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
        end else if (busy_q) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (finish)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage HI/LO unit: mul/div control, sign fix, HI/LO, stall
module ex_muldiv_unit #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    import mips_pkg::*;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 neg_res_q, neg_rem_q, div0_q, op_div_q;
    logic [WIDTH-1:0]     a_raw_q;

    logic                 accept, start_mul, start_div, signed_op, sa, sb;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 core_finish;
    logic [2*WIDTH-1:0]   core_acc;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign accept    = valid_in && !flush && (state_q == IDLE);
    assign start_mul = accept && ((funct == F_MULT) || (funct == F_MULTU));
    assign start_div = accept && ((funct == F_DIV) || (funct == F_DIVU));
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign sa        = signed_op && rs_val[WIDTH-1];
    assign sb        = signed_op && rt_val[WIDTH-1];
    assign a_mag     = sa ? -rs_val : rs_val;
    assign b_mag     = sb ? -rt_val : rt_val;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_mul || start_div),
        .is_div (start_div),
        .abort  (flush),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .finish (core_finish),
        .acc    (core_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        stall   = valid_in && is_hilo_funct(funct) && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_mul)
                    state_d = MUL;
                else if (start_div)
                    state_d = DIV;
            end
            MUL, DIV: begin
                if (flush)
                    state_d = IDLE;
                else if (core_finish)
                    state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done    = !flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divide-by-zero bypasses the engine result; the INT_MIN/-1 case falls out of negation wrap
    always_comb begin
        prod_fix = neg_res_q ? -core_acc : core_acc;
        if (!op_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = neg_rem_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
            fix_lo = neg_res_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            op_div_q  <= 1'b0;
            a_raw_q   <= '0;
        end else begin
            if (start_mul || start_div) begin
                neg_res_q <= sa ^ sb;
                neg_rem_q <= sa;
                div0_q    <= (rt_val == '0);
                op_div_q  <= start_div;
                a_raw_q   <= rs_val;
            end
            if (done) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (accept && (funct == F_MTHI)) begin
                hi_q <= rs_val;
            end else if (accept && (funct == F_MTLO)) begin
                lo_q <= rs_val;
            end
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mf_data = (funct == F_MFHI) ? hi_q : ((funct == F_MFLO) ? lo_q : '0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized bench with reference model for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, flush;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val;
    logic        stall, done;
    logic [31:0] hi, lo, mf_data;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
        .done(done), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit is_hilo(input logic [5:0] f);
        return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    endfunction

    // Architectural result of a mul/div straight from the arithmetic rules
    task automatic compute(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rhi, output logic [31:0] rlo);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = a; sb = b;
        case (f)
            6'h18: begin sp = longint'(sa) * longint'(sb); rhi = sp[63:32]; rlo = sp[31:0]; end
            6'h19: begin up = {32'b0, a} * {32'b0, b}; rhi = up[63:32]; rlo = up[31:0]; end
            default: begin
                if (b == 0) begin rhi = a; rlo = 32'hFFFF_FFFF; end
                else if (f == 6'h1A && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rhi = 0; rlo = 32'h8000_0000;
                end else if (f == 6'h1A) begin rlo = sa / sb; rhi = sa % sb; end
                else begin rlo = a / b; rhi = a % b; end
            end
        endcase
    endtask

    bit          m_busy = 0;
    int          m_age = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          done_count = 0;
    int          last_done_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_hi = 0; m_lo = 0;
            check("rst_hi", hi, 0);
            check("rst_lo", lo, 0);
            check("rst_stall", stall, 0);
            check("rst_done", done, 0);
            check("rst_mf_data", mf_data, 0);
        end else begin
            check("stall", stall, valid_in && is_hilo(funct) && m_busy);
            check("done", done, m_busy && m_age == 33 && !flush);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("mf_data", mf_data, funct == 6'h10 ? m_hi : (funct == 6'h12 ? m_lo : 32'h0));
            if (done) begin done_count++; last_done_cyc = cyc; end
            if (m_busy) begin
                if (flush) m_busy = 0;
                else if (m_age == 33) begin m_hi = p_hi; m_lo = p_lo; m_busy = 0; end
                else m_age++;
            end else if (valid_in && !flush) begin
                if (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
                    compute(funct, rs_val, rt_val, p_hi, p_lo);
                    m_busy = 1; m_age = 1;
                end else if (funct == 6'h11) m_hi = rs_val;
                else if (funct == 6'h13) m_lo = rs_val;
            end
        end
    end

    task automatic idle(input int n);
        valid_in = 0; flush = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds the op while the DUT stalls, as the ID/EX register would
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit fl, output int stalls, output logic [31:0] mf);
        logic st;
        valid_in = 1; funct = f; rs_val = a; rt_val = b; flush = fl; stalls = 0; st = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); mf = mf_data; st = stall;
            @(posedge clk); #1; flush = 0;
            if (!st) break;
            stalls++;
        end
        if (st) check("stall_bound", st, 0);
        valid_in = 0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int          t0, st_n, dc0;
    logic [31:0] mfv;
    logic [5:0]  ops [10] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h00};

    initial begin
        rst_n = 0; valid_in = 0; flush = 0; funct = 0; rs_val = 0; rt_val = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);

        t0 = cyc;
        issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st_n, mfv);
        idle(40);
        check("multu_done_latency", last_done_cyc - t0, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(6'h18, 32'hFFFF_FFF9, 32'h3, 0, st_n, mfv); idle(36);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        issue(6'h1A, 32'hFFFF_FFF9, 32'h2, 0, st_n, mfv); idle(36);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        issue(6'h1B, 32'h7, 32'h0, 0, st_n, mfv); idle(36);
        check("divu0_hi", hi, 32'h7);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0, st_n, mfv); idle(36);
        check("divovf_hi", hi, 32'h0);
        check("divovf_lo", lo, 32'h8000_0000);

        issue(6'h18, 32'd6, 32'd7, 0, st_n, mfv);
        idle(4);
        issue(6'h12, 32'h0, 32'h0, 0, st_n, mfv);
        check("mflo_stall_cycles", st_n, 29);
        check("mflo_data", mfv, 32'd42);

        issue(6'h11, 32'h1111_1111, 0, 0, st_n, mfv);
        issue(6'h13, 32'h2222_2222, 0, 0, st_n, mfv);
        dc0 = done_count;
        issue(6'h1A, 32'd100, 32'd7, 0, st_n, mfv);
        idle(9);
        flush = 1; @(posedge clk); #1; flush = 0;
        idle(40);
        check("flush_no_done", done_count, dc0);
        check("flush_hi", hi, 32'h1111_1111);
        check("flush_lo", lo, 32'h2222_2222);

        issue(6'h1A, 32'd100, 32'd7, 0, st_n, mfv);
        idle(9);
        rst_n = 0;
        @(negedge clk);
        check("rstmid_hi", hi, 0);
        check("rstmid_lo", lo, 0);
        check("rstmid_stall", stall, 0);
        @(posedge clk); #1 rst_n = 1;
        idle(2);

        issue(6'h11, 32'h1234_5678, 0, 0, st_n, mfv);
        issue(6'h10, 0, 0, 0, st_n, mfv);
        check("mfhi_stall_cycles", st_n, 0);
        check("mfhi_data", mfv, 32'h1234_5678);

        for (int i = 0; i < 250; i++) begin
            issue(ops[$urandom_range(0, 9)], rnd_val(), rnd_val(), ($urandom_range(0, 15) == 0),
                  st_n, mfv);
            if ($urandom_range(0, 2) == 0) begin
                flush = ($urandom_range(0, 11) == 0);
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; flush = 0; end
            end
        end
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
